// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions raw push-button pins before they reach the buttons PIO in_port.
// Each channel has a 2-flop synchronizer, a counter-based debounce FSM and
// registered one-cycle press/release pulses. The debounced level is always
// active-high (1 = pressed) whatever the board polarity.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   btn_raw      raw asynchronous button pins           [NUM_BUTTONS-1:0]
//   btn_state    debounced level, 1 = pressed            [NUM_BUTTONS-1:0]
//   btn_press    one-cycle pulse on an accepted press    [NUM_BUTTONS-1:0]
//   btn_release  one-cycle pulse on an accepted release  [NUM_BUTTONS-1:0]
//
// Parameters:
//   NUM_BUTTONS      number of independent channels
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a new level (>= 2)
//   CNT_WIDTH        counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//   ACTIVE_LOW       1 = raw pin reads 0 when pressed
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Synchronizer flops come out of reset at the idle pin level so that the
    // first cycles after reset never look like a press.
    localparam logic [NUM_BUTTONS-1:0] IDLE_LEVEL = {NUM_BUTTONS{ACTIVE_LOW}};
    localparam logic [CNT_WIDTH-1:0]   CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);

    logic [NUM_BUTTONS-1:0] sync_1;
    logic [NUM_BUTTONS-1:0] sync_2;
    logic [NUM_BUTTONS-1:0] sync_n;

    state_t               state   [NUM_BUTTONS];
    logic [CNT_WIDTH-1:0] counter [NUM_BUTTONS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= IDLE_LEVEL;
            sync_2 <= IDLE_LEVEL;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Polarity is normalised after the second flop: sync_n = 1 means pressed.
    assign sync_n = ACTIVE_LOW ? ~sync_2 : sync_2;

    // One FSM per channel. The counter holds the number of consecutive cycles
    // the candidate level has been seen; any reversion restarts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state[i]   <= RELEASED;
                counter[i] <= '0;
            end
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                case (state[i])
                    RELEASED: begin
                        if (sync_n[i]) begin
                            state[i]   <= PRESS_WAIT;
                            counter[i] <= CNT_ONE;
                        end else begin
                            counter[i] <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_n[i]) begin
                            state[i]   <= RELEASED;
                            counter[i] <= '0;
                        end else if (counter[i] == CNT_LAST) begin
                            state[i]     <= PRESSED;
                            counter[i]   <= '0;
                            btn_state[i] <= 1'b1;
                            btn_press[i] <= 1'b1;
                        end else begin
                            counter[i] <= counter[i] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!sync_n[i]) begin
                            state[i]   <= RELEASE_WAIT;
                            counter[i] <= CNT_ONE;
                        end else begin
                            counter[i] <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_n[i]) begin
                            state[i]   <= PRESSED;
                            counter[i] <= '0;
                        end else if (counter[i] == CNT_LAST) begin
                            state[i]       <= RELEASED;
                            counter[i]     <= '0;
                            btn_state[i]   <= 1'b0;
                            btn_release[i] <= 1'b1;
                        end else begin
                            counter[i] <= counter[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i]   <= RELEASED;
                        counter[i] <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 4,
// ACTIVE_LOW = 1, NUM_BUTTONS = 2. A run-length model predicts the outputs
// every cycle; directed checkpoints pin the expected latencies by hand.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int CW  = 3;

    logic          clk;
    logic          reset_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int assertion_count;
    int failure_count;

    button_debouncer #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH      (CW),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_state  (btn_state),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the pin level is seen by the decision logic two edges after it
    // is sampled. A channel accepts a new level once it has seen DEB
    // consecutive decision edges whose pressed-ness differs from the accepted
    // level, and emits a pulse on exactly that edge.
    logic [NB-1:0] pipe_a;
    logic [NB-1:0] pipe_b;
    int            run_len [NB];
    logic [NB-1:0] exp_state;
    logic [NB-1:0] exp_press;
    logic [NB-1:0] exp_release;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_a      = '1;
            pipe_b      = '1;
            exp_state   = '0;
            exp_press   = '0;
            exp_release = '0;
            for (int i = 0; i < NB; i++) run_len[i] = 0;
        end else begin
            exp_press   = '0;
            exp_release = '0;
            for (int i = 0; i < NB; i++) begin
                logic pressed_now;
                pressed_now = ~pipe_b[i];
                if (pressed_now != exp_state[i]) begin
                    run_len[i] = run_len[i] + 1;
                    if (run_len[i] == DEB) begin
                        exp_state[i] = pressed_now;
                        if (pressed_now) exp_press[i] = 1'b1;
                        else             exp_release[i] = 1'b1;
                        run_len[i] = 0;
                    end
                end else begin
                    run_len[i] = 0;
                end
            end
            pipe_b = pipe_a;
            pipe_a = btn_raw;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        assertion_count++;
        if (btn_state !== exp_state || btn_press !== exp_press || btn_release !== exp_release) begin
            failure_count++;
            $display("[TB] FAIL model_cycle t=%0t actual state=%b press=%b release=%b required state=%b press=%b release=%b",
                     $time, btn_state, btn_press, btn_release, exp_state, exp_press, exp_release);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive a raw pattern at a falling edge and let n falling edges pass.
    task automatic applyStimulus(input logic [NB-1:0] raw, input int n);
        btn_raw = raw;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [NB-1:0] s,
                               input logic [NB-1:0] p, input logic [NB-1:0] r);
        assertion_count++;
        if (btn_state !== s) begin
            failure_count++;
            $display("[TB] FAIL %s.state actual=%b required=%b", name, btn_state, s);
        end
        assertion_count++;
        if (btn_press !== p) begin
            failure_count++;
            $display("[TB] FAIL %s.press actual=%b required=%b", name, btn_press, p);
        end
        assertion_count++;
        if (btn_release !== r) begin
            failure_count++;
            $display("[TB] FAIL %s.release actual=%b required=%b", name, btn_release, r);
        end
    endtask

    initial begin
        assertion_count = 0;
        failure_count   = 0;
        reset_n = 1'b0;
        btn_raw = 2'b11;
        repeat (3) @(negedge clk);
        checkOutput("reset", 2'b00, 2'b00, 2'b00);

        // 1. Idle after reset: nothing may change.
        reset_n = 1'b1;
        applyStimulus(2'b11, 20);
        checkOutput("idle20", 2'b00, 2'b00, 2'b00);

        // 2. Press on channel 0: accepted on edge N+5, pulse gone on N+6.
        applyStimulus(2'b10, 5);
        checkOutput("press0_early", 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b10, 1);
        checkOutput("press0_accept", 2'b01, 2'b01, 2'b00);
        applyStimulus(2'b10, 1);
        checkOutput("press0_pulse_end", 2'b01, 2'b00, 2'b00);

        // 3. Bounce on channel 1: 3 low, 1 high, then low from edge M.
        applyStimulus(2'b00, 3);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b00, 5);
        checkOutput("bounce1_early", 2'b01, 2'b00, 2'b00);
        applyStimulus(2'b00, 1);
        checkOutput("bounce1_accept", 2'b11, 2'b10, 2'b00);
        applyStimulus(2'b00, 1);
        checkOutput("bounce1_pulse_end", 2'b11, 2'b00, 2'b00);

        // 4. Both released on the same sampling edge.
        applyStimulus(2'b11, 5);
        checkOutput("release_early", 2'b11, 2'b00, 2'b00);
        applyStimulus(2'b11, 1);
        checkOutput("release_both", 2'b00, 2'b00, 2'b11);
        applyStimulus(2'b11, 1);
        checkOutput("release_pulse_end", 2'b00, 2'b00, 2'b00);

        // 5. Two-cycle glitch on channel 0 is rejected.
        applyStimulus(2'b10, 2);
        applyStimulus(2'b11, 8);
        checkOutput("glitch0", 2'b00, 2'b00, 2'b00);

        // 6. Reset two cycles into PRESS_WAIT, button kept held.
        applyStimulus(2'b10, 4);
        checkOutput("pre_reset_wait", 2'b00, 2'b00, 2'b00);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_wait", 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(2'b10, 5);
        checkOutput("requal_early", 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b10, 1);
        checkOutput("requal_accept", 2'b01, 2'b01, 2'b00);
        applyStimulus(2'b10, 1);
        checkOutput("requal_pulse_end", 2'b01, 2'b00, 2'b00);

        // Asynchronous reset while pressed clears outputs between edges.
        applyStimulus(2'b10, 3);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_pressed", 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(2'b11, 10);
        checkOutput("final_idle", 2'b00, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
        $finish;
    end

endmodule
